dragon_length_ctrl: RTL

Frame-rate controller that sequences the dragon body's growth and shrink requests and paces its movement. Collects asynchronous-to-frame heal/hit event pulses from collision logic, arbitrates them, and issues at most one single-cycle `lengthUpdate` pulse per frame to the body segment queue. Also generates the body's `movementCounter`, tracks the current segment count, applies post-hit invulnerability, and flags game over.

---
 rtl/dragon_length_ctrl_if.sv | 38 +++
 rtl/dragon_length_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dragon_length_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dragon_length_ctrl_if
// Description : Bundles the frame-sync/request inputs and the body-facing
//               outputs of the dragon length controller.
//               master : collision/video side (drives vsync and requests)
//               slave  : dragon_length_ctrl (drives body-facing outputs)
//   vsync           frame sync level, sampled on clk
//   heal_req        one-clk grow request pulse
//   hit_req         one-clk shrink request pulse
//   lengthUpdate    01 HEAL, 10 HIT, 00 otherwise (single clk)
//   movementCounter frame counter to the body
//   dragon_len      current segment count
//   invuln          high while hits are ignored
//   game_over       sticky, high after a hit at length 0
// Revision    : 1.0 - initial release
// ============================================================================
interface dragon_length_ctrl_if;
   logic       vsync;
   logic       heal_req;
   logic       hit_req;
   logic [1:0] lengthUpdate;
   logic [5:0] movementCounter;
   logic [2:0] dragon_len;
   logic       invuln;
   logic       game_over;

   modport master (
      output vsync, heal_req, hit_req,
      input  lengthUpdate, movementCounter, dragon_len, invuln, game_over
   );

   modport slave (
      input  vsync, heal_req, hit_req,
      output lengthUpdate, movementCounter, dragon_len, invuln, game_over
   );
endinterface
`default_nettype wire

// File: rtl/dragon_length_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dragon_length_ctrl
// Description : Frame-rate controller for the dragon body. Collects heal/hit
//               request pulses, arbitrates them (hit first) and issues at most
//               one single-clk lengthUpdate pulse per frame. Also generates
//               movementCounter, tracks the segment count, applies post-hit
//               invulnerability and flags game over.
// Ports       : clk    - system clock
//               reset  - synchronous, active-low
//               bus    - dragon_length_ctrl_if.slave (vsync, heal_req,
//                        hit_req in; lengthUpdate, movementCounter,
//                        dragon_len, invuln, game_over out)
// Config      : DRAGON_LEN_CTRL_INVULN_EN - when defined, an applied hit
//               makes further hits ignored for INVULN_FRAMES frames; when
//               undefined invuln is tied 0 and every hit_req is latched.
// Revision    : 1.0 - initial release
// ============================================================================
module dragon_length_ctrl #(
   parameter int MOVE_PERIOD   = 20,
   parameter int INVULN_FRAMES = 60,
   parameter int MAX_LEN       = 7
) (
   input  wire logic           clk,
   input  wire logic           reset,
   dragon_length_ctrl_if.slave bus
);

   localparam logic [1:0] UPD_NONE = 2'b00;
   localparam logic [1:0] UPD_HEAL = 2'b01;
   localparam logic [1:0] UPD_HIT  = 2'b10;
   localparam logic [2:0] LEN_MAX  = 3'(MAX_LEN);
   localparam logic [5:0] MC_LAST  = 6'(MOVE_PERIOD - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_OVER  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       vsync_q, vsync_qq;
   logic       frame_tick;
   logic [1:0] heal_pend_q, heal_pend_d;
   logic       hit_pend_q, hit_pend_d;
   logic [1:0] upd_q, upd_d;
   logic [5:0] mc_q, mc_d;
   logic [2:0] len_q, len_d;
   logic       over_q, over_d;
   logic       heal_dec;
   logic       heal_inc;
   logic       invuln_load;
   logic       invuln_w;

   // vsync_q is the sampled level; the tick is formed one stage later so
   // it is high in the cycle after the edge that first sees vsync high.
   assign frame_tick = vsync_q & ~vsync_qq;

   always_comb begin
      state_d     = state_q;
      hit_pend_d  = hit_pend_q;
      heal_pend_d = heal_pend_q;
      upd_d       = UPD_NONE;
      len_d       = len_q;
      over_d      = over_q;
      mc_d        = mc_q;
      heal_dec    = 1'b0;
      heal_inc    = 1'b0;
      invuln_load = 1'b0;

      // The arbitration result is registered on the tick edge, so the
      // pulse, dragon_len and invuln all appear together in S_ISSUE.
      case (state_q)
         S_IDLE: begin
            if (frame_tick && (hit_pend_q || (heal_pend_q != 2'd0))) begin
               state_d = S_ISSUE;
               if (hit_pend_q) begin
                  hit_pend_d = 1'b0;
                  if (len_q != 3'd0) begin
                     upd_d       = UPD_HIT;
                     len_d       = len_q - 3'd1;
                     invuln_load = 1'b1;
                  end else begin
                     over_d = 1'b1;
                  end
               end else begin
                  heal_dec = 1'b1;
                  if (len_q < LEN_MAX) begin
                     upd_d = UPD_HEAL;
                     len_d = len_q + 3'd1;
                  end
               end
            end
         end
         S_ISSUE: state_d = over_q ? S_OVER : S_IDLE;
         default: state_d = S_OVER;
      endcase

      if (state_q != S_OVER) begin
         // A request on the tick edge sets the pend after it was consumed.
         if (bus.hit_req && !invuln_w) begin
            hit_pend_d = 1'b1;
         end
         heal_inc = bus.heal_req && ((heal_pend_q != 2'd3) || heal_dec);
         if (frame_tick) begin
            mc_d = (mc_q == MC_LAST) ? 6'd0 : mc_q + 6'd1;
         end
      end

      case ({heal_inc, heal_dec})
         2'b10:   heal_pend_d = heal_pend_q + 2'd1;
         2'b01:   heal_pend_d = heal_pend_q - 2'd1;
         default: heal_pend_d = heal_pend_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         vsync_q     <= 1'b0;
         vsync_qq    <= 1'b0;
         heal_pend_q <= 2'd0;
         hit_pend_q  <= 1'b0;
         upd_q       <= UPD_NONE;
         mc_q        <= 6'd0;
         len_q       <= 3'd0;
         over_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vsync_q     <= bus.vsync;
         vsync_qq    <= vsync_q;
         heal_pend_q <= heal_pend_d;
         hit_pend_q  <= hit_pend_d;
         upd_q       <= upd_d;
         mc_q        <= mc_d;
         len_q       <= len_d;
         over_q      <= over_d;
      end
   end

`ifdef DRAGON_LEN_CTRL_INVULN_EN
   localparam int          INV_W    = $clog2(INVULN_FRAMES + 1);
   localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);

   logic [INV_W-1:0] inv_cnt_q;

   // A load on the tick edge takes precedence over that tick's decrement.
   always_ff @(posedge clk) begin
      if (!reset) begin
         inv_cnt_q <= '0;
      end else if (invuln_load) begin
         inv_cnt_q <= INV_LOAD;
      end else if (frame_tick && (inv_cnt_q != '0)) begin
         inv_cnt_q <= inv_cnt_q - 1'b1;
      end
   end

   assign invuln_w = (inv_cnt_q != '0);
`else
   assign invuln_w = 1'b0;
   wire unused_invuln = invuln_load ^ (INVULN_FRAMES != 0);
`endif

   assign bus.lengthUpdate    = upd_q;
   assign bus.movementCounter = mc_q;
   assign bus.dragon_len      = len_q;
   assign bus.invuln          = invuln_w;
   assign bus.game_over       = over_q;

endmodule
`default_nettype wire
